pipe_hazard_ctrl: RTL
=====================

# pipe_hazard_ctrl

Pipeline sequencing controller for the RV32I core. Combines load-use hazard requests from the operand-forwarding unit, taken branch/jump redirects from the ALU stage and data-memory handshake status from the MEM stage into per-stage enable and bubble controls. Owns a small FSM covering memory wait, bus timeout and halt, plus stall and flush performance counters. Sits beside the forwarding unit and drives the IF/DE/ALU/MEM/WB pipeline registers.

## Interface
- MEM_TIMEOUT, 16: maximum consecutive MEM wait cycles before bus error (≥2).
- CNT_W, 32: width of the performance counters.

- clk  in  1  core clock.
- rstn  in  1  asynchronous active-low reset.
- WaitLoad_1  in  1  load-use hazard between DE and ALU, from the forwarding unit.
- ALU_Redirect_1  in  1  taken branch/jump in the ALU stage.
- ALU_RedirectPC_32  in  32  redirect target.
- MEM_MemReq_1  in  1  MEM stage holds a valid load/store.
- DMemReady_1  in  1  data memory completes the access this cycle.
- MEM_Ecall_1  in  1  ECALL/EBREAK reached MEM.
- IF_En_1, DE_En_1, ALU_En_1, MEM_En_1  out  1 each  pipeline register load enables.
- ALU_Bubble_1, MEM_Bubble_1, WB_Bubble_1  out  1 each  load a NOP into that stage register instead of upstream data.
- DE_Bubble_1  out  1  discard the fetched instruction.
- PCRedirect_1  out  1  PC mux selects ALU_RedirectPC_32.
- RedirectPC_32  out  32  pass-through of the target.
- BusError_1  out  1  sticky memory timeout flag.
- Halted_1  out  1  core stopped.
- StallCycles  out  CNT_W  cycles with IF_En_1 low while in RUN/MEM_WAIT.
- FlushCount  out  CNT_W  number of redirects taken.

## Operation
- FSM states: RUN, MEM_WAIT, HALT. Reset enters RUN.
- RUN: MEM_MemReq_1 & ~DMemReady_1 → MEM_WAIT; MEM_Ecall_1 → HALT (takes priority).
- MEM_WAIT: DMemReady_1 → RUN; wait counter reaching MEM_TIMEOUT without ready → HALT with BusError_1 set.
- HALT: absorbing until reset.
- Memory stall condition (MemStall) = MEM_MemReq_1 & ~DMemReady_1 in RUN or MEM_WAIT.
- Priority, highest first:
  - HALT: all enables 0; no bubbles; PCRedirect_1 = 0.
  - MemStall: all enables 0; WB_Bubble_1 = 1; redirect and load-use ignored. They persist because ALU/DE are frozen.
  - Redirect: all enables 1; DE_Bubble_1 = ALU_Bubble_1 = 1; PCRedirect_1 = 1; WaitLoad_1 ignored (wrong-path).
  - Load-use: IF_En_1 = DE_En_1 = 0; ALU_En_1 = MEM_En_1 = 1; ALU_Bubble_1 = 1.
  - Otherwise all enables 1, no bubbles.
- MEM_Bubble_1 = 0 always (reserved); RedirectPC_32 = ALU_RedirectPC_32 always.
- Wait counter: clog2(MEM_TIMEOUT+1) bits. Cleared in RUN. Increments each MEM_WAIT cycle without ready.
- Counters wrap modulo 2^CNT_W. StallCycles increments in any non-HALT cycle with IF_En_1 = 0. FlushCount increments when PCRedirect_1 = 1.

## Timing
- Reset values: state RUN, wait counter 0, BusError_1 0, Halted_1 0, StallCycles 0, FlushCount 0.
- Combinational outputs after reset follow the RUN equations.
- Enables, bubbles and PCRedirect_1 are combinational from current state and inputs: zero latency.
- BusError_1, Halted_1, state and counters are registered and update on the next rising edge.
- Single-cycle access: ready in the same cycle as the request. No stall, and the FSM stays in RUN.
- Timeout: request first seen in cycle 0, never ready. MEM_WAIT spans cycles 1..MEM_TIMEOUT. HALT and BusError_1 are visible from cycle MEM_TIMEOUT+1.
- Ready in the same cycle the counter would hit MEM_TIMEOUT: ready wins, return to RUN, no error.
- Ecall together with a MEM stall: Ecall wins and goes to HALT; the pending access is abandoned.
- Asynchronous reset mid-MEM_WAIT or in HALT returns the block to RUN immediately and clears all registers.

## Test plan
- Load-use: WaitLoad_1 = 1 for one cycle, no other events → IF/DE_En = 0, ALU_Bubble_1 = 1, StallCycles increments 0→1. The next cycle has all enables at 1.
- Redirect with simultaneous WaitLoad_1, target 0x0000_0100 → PCRedirect_1 = 1, RedirectPC_32 = 0x100, DE/ALU bubbles = 1, all enables = 1, FlushCount 0→1, StallCycles unchanged.
- Memory wait of 3 cycles (ready on the 4th), with ALU_Redirect_1 held → enables = 0 and WB_Bubble_1 = 1 for 3 cycles, no PCRedirect_1. In the ready cycle, redirect fires; state returns to RUN; StallCycles = 3.
- Timeout with MEM_TIMEOUT = 4 and ready never asserted → BusError_1 = 1 and Halted_1 = 1 from the 6th cycle after the request. Enables stay 0 afterwards regardless of inputs.
- MEM_Ecall_1 = 1 with MEM_MemReq_1 = 1 and DMemReady_1 = 0 → HALT next cycle, BusError_1 = 0.
- rstn pulsed low in HALT with counters non-zero → all registers 0, state RUN, enables 1 after release.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline sequencing bus between the RV32I pipeline stages and the hazard controller.
// The pipeline side (master) supplies hazard/handshake status; the controller (slave) returns stage controls.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             WaitLoad_1;
  logic             ALU_Redirect_1;
  logic [31:0]      ALU_RedirectPC_32;
  logic             MEM_MemReq_1;
  logic             DMemReady_1;
  logic             MEM_Ecall_1;

  logic             IF_En_1;
  logic             DE_En_1;
  logic             ALU_En_1;
  logic             MEM_En_1;
  logic             DE_Bubble_1;
  logic             ALU_Bubble_1;
  logic             MEM_Bubble_1;
  logic             WB_Bubble_1;
  logic             PCRedirect_1;
  logic [31:0]      RedirectPC_32;
  logic             BusError_1;
  logic             Halted_1;
  logic [CNT_W-1:0] StallCycles;
  logic [CNT_W-1:0] FlushCount;

  modport master (
    output WaitLoad_1, ALU_Redirect_1, ALU_RedirectPC_32,
    output MEM_MemReq_1, DMemReady_1, MEM_Ecall_1,
    input  IF_En_1, DE_En_1, ALU_En_1, MEM_En_1,
    input  DE_Bubble_1, ALU_Bubble_1, MEM_Bubble_1, WB_Bubble_1,
    input  PCRedirect_1, RedirectPC_32, BusError_1, Halted_1,
    input  StallCycles, FlushCount
  );

  modport slave (
    input  WaitLoad_1, ALU_Redirect_1, ALU_RedirectPC_32,
    input  MEM_MemReq_1, DMemReady_1, MEM_Ecall_1,
    output IF_En_1, DE_En_1, ALU_En_1, MEM_En_1,
    output DE_Bubble_1, ALU_Bubble_1, MEM_Bubble_1, WB_Bubble_1,
    output PCRedirect_1, RedirectPC_32, BusError_1, Halted_1,
    output StallCycles, FlushCount
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: merges load-use, redirect and data-memory status into
// per-stage enables/bubbles, tracks memory wait / bus timeout / halt and counts stalls and flushes.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rstn,
  pipe_hazard_ctrl_if.slave hz
);

  localparam int WCW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_t;

  state_t           state;
  logic [WCW-1:0]   waitCnt;
  logic             busErrorR;
  logic             haltedR;
  logic [CNT_W-1:0] stallCntR;
  logic [CNT_W-1:0] flushCntR;

  logic memStall;
  logic ifEn;
  logic deEn;
  logic aluEn;
  logic memEn;
  logic deBubble;
  logic aluBubble;
  logic wbBubble;
  logic pcRedirect;

  // Stage controls: halt > memory stall > redirect > load-use > free run.
  always_comb begin
    memStall   = 1'b0;
    ifEn       = 1'b0;
    deEn       = 1'b0;
    aluEn      = 1'b0;
    memEn      = 1'b0;
    deBubble   = 1'b0;
    aluBubble  = 1'b0;
    wbBubble   = 1'b0;
    pcRedirect = 1'b0;
    case (state)
      RUN, MEM_WAIT: begin
        memStall = hz.MEM_MemReq_1 & ~hz.DMemReady_1;
        if (memStall) begin
          // Frozen upstream stages keep the redirect/load-use requests alive for later.
          wbBubble = 1'b1;
        end else if (hz.ALU_Redirect_1) begin
          ifEn       = 1'b1;
          deEn       = 1'b1;
          aluEn      = 1'b1;
          memEn      = 1'b1;
          deBubble   = 1'b1;
          aluBubble  = 1'b1;
          pcRedirect = 1'b1;
        end else if (hz.WaitLoad_1) begin
          aluEn     = 1'b1;
          memEn     = 1'b1;
          aluBubble = 1'b1;
        end else begin
          ifEn  = 1'b1;
          deEn  = 1'b1;
          aluEn = 1'b1;
          memEn = 1'b1;
        end
      end
      HALT: begin
        memStall = 1'b0;
      end
      default: begin
        memStall = 1'b0;
      end
    endcase
  end

  // Sequencing FSM with wait counter, sticky status flags and performance counters.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= RUN;
      waitCnt   <= '0;
      busErrorR <= 1'b0;
      haltedR   <= 1'b0;
      stallCntR <= '0;
      flushCntR <= '0;
    end else begin
      if ((state != HALT) && !ifEn) begin
        stallCntR <= stallCntR + CNT_W'(1);
      end
      if (pcRedirect) begin
        flushCntR <= flushCntR + CNT_W'(1);
      end
      case (state)
        RUN: begin
          waitCnt <= '0;
          if (hz.MEM_Ecall_1) begin
            state   <= HALT;
            haltedR <= 1'b1;
          end else if (memStall) begin
            state <= MEM_WAIT;
          end else begin
            state <= RUN;
          end
        end
        MEM_WAIT: begin
          if (hz.MEM_Ecall_1) begin
            state   <= HALT;
            haltedR <= 1'b1;
          end else if (hz.DMemReady_1 || !hz.MEM_MemReq_1) begin
            // A dropped request is treated like completion so the FSM never waits on nothing.
            state   <= RUN;
            waitCnt <= '0;
          end else if (waitCnt == WAIT_LAST) begin
            state     <= HALT;
            waitCnt   <= waitCnt + WCW'(1);
            busErrorR <= 1'b1;
            haltedR   <= 1'b1;
          end else begin
            waitCnt <= waitCnt + WCW'(1);
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

  assign hz.IF_En_1       = ifEn;
  assign hz.DE_En_1       = deEn;
  assign hz.ALU_En_1      = aluEn;
  assign hz.MEM_En_1      = memEn;
  assign hz.DE_Bubble_1   = deBubble;
  assign hz.ALU_Bubble_1  = aluBubble;
  assign hz.MEM_Bubble_1  = 1'b0;
  assign hz.WB_Bubble_1   = wbBubble;
  assign hz.PCRedirect_1  = pcRedirect;
  assign hz.RedirectPC_32 = hz.ALU_RedirectPC_32;
  assign hz.BusError_1    = busErrorR;
  assign hz.Halted_1      = haltedR;
  assign hz.StallCycles   = stallCntR;
  assign hz.FlushCount    = flushCntR;

endmodule
